tick_sequencer: RTL and testbench
=================================

// Module: tick_sequencer
// PURPOSE
//   Run controller for a programmable modulo counter. Emits a one-cycle tick
//   every DIV cycles in continuous or one-shot mode. Accepts new divide values
//   over a valid/ready handshake. In RUN, a new value is staged in a shadow
//   register and takes effect at the next wrap, so no period is ever truncated.
//   Sits between the host/config logic and the waveform generator's rate
//   counters, which it replaces/drives.
// PARAMETERS
//   W        16   counter/divider width; legal DIV range 1 .. 2^W-1
//   DEF_DIV  33   active divide value after reset (must be 1 .. 2^W-1)
// PORTS
//   clk           in   1  clock; all logic on posedge
//   rst           in   1  synchronous, active-high reset
//   start         in   1  begin counting (sampled in IDLE only)
//   start_oneshot in   1  sampled with start: 1 = stop after first tick
//   stop          in   1  abort run, return to IDLE
//   cfg_valid     in   1  divide-value offer
//   cfg_div       in   W  divide value offered
//   cfg_ready     out  1  controller can accept cfg_div this cycle
//   tick          out  1  registered one-cycle pulse at each period end
//   busy          out  1  1 while in RUN
//   count         out  W  current counter value, 0 .. div_q-1
//   err           out  1  one-cycle pulse: cfg_div==0 was offered and dropped
// BEHAVIOUR
//   Reset: state=IDLE, count=0, div_q=DEF_DIV, pend=0, tick=0, busy=0, err=0,
//     cfg_ready=1; any run, staged value and oneshot flag are discarded.
//   States: IDLE, RUN. busy is registered and equals (state==RUN).
//   IDLE->RUN: edge with start=1 and stop=0.
//     - count<=0 at that edge; oneshot flag <= start_oneshot.
//     - start together with stop: stays IDLE.
//     - start while in RUN: ignored.
//   RUN counting: count+1 each edge. At the edge where count==div_q-1:
//     - count<=0 and tick<=1 for exactly one cycle.
//     - Start at edge E0 gives ticks after E0+div, E0+2*div, ...
//     - div_q=1: count stays 0; tick is high every cycle from E0+1.
//   One-shot: at the first wrap edge, tick<=1 and state<=IDLE (busy falls
//     together with the tick rising).
//   RUN->IDLE on stop: at the next edge count<=0 and no tick. A stop on the
//     same edge as a wrap wins, so that tick is suppressed.
//   Config handshake: a value is accepted on an edge with cfg_valid&cfg_ready.
//     - cfg_div==0: accepted and dropped; err<=1 for one cycle; div_q and
//       pend unchanged.
//     - In IDLE: div_q<=cfg_div immediately; cfg_ready stays 1. With start on
//       the same edge, the new value governs the run just started.
//     - In RUN: shadow<=cfg_div, pend<=1, so cfg_ready=0 from the next cycle.
//       At the next wrap edge: div_q<=shadow, pend<=0, cfg_ready<=1. The tick
//       that ends the old period is still issued; the following period uses
//       the new value.
//     - Accept on the same edge as a wrap: staged, applied at the following
//       wrap.
//     - On stop, or one-shot end, with pend=1: shadow is applied on entry to
//       IDLE.
//   cfg_ready = !pend (registered). count, tick and err are all registered.
//   Arithmetic: unsigned W-bit. The count compare uses div_q-1, never a wrap
//     to 2^W.
// TESTING
//   1 rst; start (cont), DEF_DIV=33 -> tick after 33,66,99 cycles; count 0..32.
//   2 IDLE cfg_div=4, start oneshot -> single tick after 4 cycles, busy 1->0
//     on same edge, count=0.
//   3 RUN div=10, cfg_div=3 at count=5 -> cfg_ready=0; ticks at +10 then
//     every 3; cfg_ready=1 after the wrap.
//   4 RUN div=8, stop on edge where count=7 -> no tick, IDLE, count=0.
//   5 cfg_div=0 offered -> err one-cycle pulse, div_q unchanged; cfg_div=1,
//     start -> tick every cycle.
//   6 rst asserted mid-run with pend=1 -> next cycle all outputs at reset
//     values, div_q=33.

Source files
------------

// File: rtl/tick_sequencer.sv
// rtl/tick_sequencer.sv - programmable modulo tick generator with staged divide reload
// Continuous or one-shot tick every div_q cycles; divide updates in RUN wait for the next wrap.
module tick_sequencer #(
  parameter int          W       = 16,
  parameter int unsigned DEF_DIV = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         start_oneshot,
  input  logic         stop,
  input  logic         cfg_valid,
  input  logic [W-1:0] cfg_div,
  output logic         cfg_ready,
  output logic         tick,
  output logic         busy,
  output logic [W-1:0] count,
  output logic         err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]   state_q, state_d;
  logic [W-1:0] count_q, count_d;
  logic [W-1:0] div_q, div_d;
  logic [W-1:0] shadow_q, shadow_d;
  logic         pend_q, pend_d;
  logic         oneshot_q, oneshot_d;
  logic         tick_q, tick_d;
  logic         busy_q, busy_d;
  logic         err_q, err_d;

  logic accept;
  logic cfg_nz;
  logic last;

  assign accept = cfg_valid & ~pend_q;
  assign cfg_nz = accept & (cfg_div != '0);
  // div_q is never 0, so div_q-1 cannot underflow.
  assign last   = (count_q == div_q - W'(1));

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    div_d     = div_q;
    shadow_d  = shadow_q;
    pend_d    = pend_q;
    oneshot_d = oneshot_q;
    tick_d    = 1'b0;
    err_d     = accept & (cfg_div == '0);
    case (state_q)
      S_IDLE: begin
        count_d = '0;
        if (cfg_nz) div_d = cfg_div;
        if (start && !stop) begin
          state_d   = S_RUN;
          oneshot_d = start_oneshot;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
          count_d = '0;
          pend_d  = 1'b0;
          if (cfg_nz) div_d = cfg_div;
          else if (pend_q) div_d = shadow_q;
        end else if (last) begin
          count_d = '0;
          tick_d  = 1'b1;
          pend_d  = 1'b0;
          if (pend_q) div_d = shadow_q;
          if (oneshot_q) begin
            state_d = S_IDLE;
            if (cfg_nz) div_d = cfg_div;
          end else if (cfg_nz) begin
            // Accepted on the wrap edge: governs the period after next.
            shadow_d = cfg_div;
            pend_d   = 1'b1;
          end
        end else begin
          count_d = count_q + W'(1);
          if (cfg_nz) begin
            shadow_d = cfg_div;
            pend_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      div_q     <= W'(DEF_DIV);
      shadow_q  <= '0;
      pend_q    <= 1'b0;
      oneshot_q <= 1'b0;
      tick_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      div_q     <= div_d;
      shadow_q  <= shadow_d;
      pend_q    <= pend_d;
      oneshot_q <= oneshot_d;
      tick_q    <= tick_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign cfg_ready = ~pend_q;
  assign tick      = tick_q;
  assign busy      = busy_q;
  assign count     = count_q;
  assign err       = err_q;

endmodule

// File: tb/tb_tick_sequencer.sv
// tb/tb_tick_sequencer.sv - directed and randomized checks of tick_sequencer against a time-based model
module tb_tick_sequencer;

  localparam int W = 16;
  localparam int DEF = 33;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         start_oneshot = 1'b0;
  logic         stop = 1'b0;
  logic         cfg_valid = 1'b0;
  logic [W-1:0] cfg_div = '0;
  logic         cfg_ready;
  logic         tick;
  logic         busy;
  logic [W-1:0] count;
  logic         err;

  tick_sequencer #(.W(W), .DEF_DIV(DEF)) dut (
    .clk(clk), .rst(rst), .start(start), .start_oneshot(start_oneshot), .stop(stop),
    .cfg_valid(cfg_valid), .cfg_div(cfg_div), .cfg_ready(cfg_ready),
    .tick(tick), .busy(busy), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a run is described by the edge index where the current period began;
  // a period ends when exactly div edges have elapsed since then.
  int  cyc = 0;
  bit  m_ok = 0, m_run = 0, m_one = 0, m_stg = 0, m_tick = 0, m_err = 0;
  bit  m_acc, m_nz, m_end;
  int  m_div = DEF, m_sval = 0, m_pstart = 0, m_count = 0;

  always @(posedge clk) begin
    cyc++;
    m_acc  = cfg_valid && !m_stg;
    m_tick = 0;
    m_err  = 0;
    if (rst) begin
      m_ok = 1; m_run = 0; m_div = DEF; m_stg = 0; m_one = 0; m_pstart = cyc;
    end else begin
      m_err = m_acc && (cfg_div == 0);
      m_nz  = m_acc && (cfg_div != 0);
      if (!m_run) begin
        if (m_nz) m_div = int'(cfg_div);
        if (start && !stop) begin
          m_run = 1; m_one = start_oneshot; m_pstart = cyc;
        end
      end else begin
        m_end = (cyc - m_pstart) == m_div;
        if (stop) begin
          m_run = 0;
          if (m_nz) begin m_stg = 1; m_sval = int'(cfg_div); end
          if (m_stg) begin m_div = m_sval; m_stg = 0; end
        end else if (m_end) begin
          m_tick = 1;
          m_pstart = cyc;
          if (m_stg) begin m_div = m_sval; m_stg = 0; end
          if (m_nz) begin m_stg = 1; m_sval = int'(cfg_div); end
          if (m_one) begin
            m_run = 0;
            if (m_stg) begin m_div = m_sval; m_stg = 0; end
          end
        end else if (m_nz) begin
          m_stg = 1; m_sval = int'(cfg_div);
        end
      end
    end
    m_count = m_run ? (cyc - m_pstart) : 0;
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("sb_tick", int'(tick), int'(m_tick));
      check("sb_busy", int'(busy), int'(m_run));
      check("sb_count", int'(count), m_count);
      check("sb_err", int'(err), int'(m_err));
      check("sb_cfg_ready", int'(cfg_ready), int'(!m_stg));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic stepn(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // 1: reset then continuous run at DEF_DIV
    rst = 1; step(); rst = 0;
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(cfg_ready), 1);
    check("rst_count", int'(count), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_err", int'(err), 0);
    start = 1; step(); start = 0;
    check("t1_busy", int'(busy), 1);
    check("t1_count0", int'(count), 0);
    stepn(32);
    check("t1_count32", int'(count), 32);
    check("t1_notick", int'(tick), 0);
    step();
    check("t1_tick33", int'(tick), 1);
    check("t1_wrap", int'(count), 0);
    stepn(33);
    check("t1_tick66", int'(tick), 1);
    stepn(33);
    check("t1_tick99", int'(tick), 1);
    stop = 1; step(); stop = 0;
    check("t1_stopped", int'(busy), 0);

    // 2: one-shot with div 4
    cfg_valid = 1; cfg_div = 4; step(); cfg_valid = 0;
    start = 1; start_oneshot = 1; step(); start = 0; start_oneshot = 0;
    stepn(3);
    check("t2_count3", int'(count), 3);
    check("t2_busy", int'(busy), 1);
    step();
    check("t2_tick", int'(tick), 1);
    check("t2_busy_fall", int'(busy), 0);
    check("t2_count", int'(count), 0);
    step();
    check("t2_single", int'(tick), 0);

    // 3: staged reload 10 -> 3
    cfg_valid = 1; cfg_div = 10; step(); cfg_valid = 0;
    start = 1; step(); start = 0;
    stepn(5);
    check("t3_count5", int'(count), 5);
    cfg_valid = 1; cfg_div = 3; step(); cfg_valid = 0;
    check("t3_ready0", int'(cfg_ready), 0);
    stepn(3);
    check("t3_notick", int'(tick), 0);
    step();
    check("t3_tick10", int'(tick), 1);
    check("t3_ready1", int'(cfg_ready), 1);
    stepn(2);
    check("t3_gap", int'(tick), 0);
    step();
    check("t3_tick3", int'(tick), 1);
    stop = 1; step(); stop = 0;

    // 4: stop on the wrap edge suppresses the tick
    cfg_valid = 1; cfg_div = 8; step(); cfg_valid = 0;
    start = 1; step(); start = 0;
    stepn(7);
    check("t4_count7", int'(count), 7);
    stop = 1; step(); stop = 0;
    check("t4_notick", int'(tick), 0);
    check("t4_idle", int'(busy), 0);
    check("t4_count", int'(count), 0);

    // 5: zero divide rejected, then div 1 ticks every cycle
    cfg_valid = 1; cfg_div = 0; step(); cfg_valid = 0;
    check("t5_err", int'(err), 1);
    step();
    check("t5_err_pulse", int'(err), 0);
    cfg_valid = 1; cfg_div = 1; start = 1; step(); cfg_valid = 0; start = 0;
    step();
    check("t5_tick_a", int'(tick), 1);
    step();
    check("t5_tick_b", int'(tick), 1);
    check("t5_count", int'(count), 0);
    stop = 1; step(); stop = 0;

    // 6: reset mid-run with a staged value restores DEF_DIV
    cfg_valid = 1; cfg_div = 5; start = 1; step(); cfg_valid = 0; start = 0;
    cfg_valid = 1; cfg_div = 7; step(); cfg_valid = 0;
    check("t6_pend", int'(cfg_ready), 0);
    rst = 1; step(); rst = 0;
    check("t6_ready", int'(cfg_ready), 1);
    check("t6_busy", int'(busy), 0);
    check("t6_count", int'(count), 0);
    start = 1; step(); start = 0;
    stepn(32);
    check("t6_notick", int'(tick), 0);
    step();
    check("t6_tick33", int'(tick), 1);

    // Randomized traffic, checked by the scoreboard every cycle
    for (int i = 0; i < 4000; i++) begin
      rst           = ($urandom % 300) == 0;
      start         = ($urandom % 8) == 0;
      start_oneshot = ($urandom % 3) == 0;
      stop          = ($urandom % 40) == 0;
      cfg_valid     = ($urandom % 5) == 0;
      cfg_div       = W'($urandom_range(0, 12));
      step();
    end
    rst = 0; start = 0; stop = 0; cfg_valid = 0;
    stepn(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
